// File: rtl/reg_writeback.sv
// rtl/reg_writeback.sv - merges ALU results and buffered load returns into one register-file write per cycle
module reg_writeback #(
  parameter int DATA_W     = 16,
  parameter int FLAG_W     = 5,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [3:0]        alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              alu_fvalid,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic              alu_stall,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [3:0]        ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] wb_data,
  output logic [15:0]       wb_enable,
  output logic [FLAG_W-1:0] wb_flags,
  output logic              wb_flags_en,
  output logic [15:0]       pend_mask,
  output logic              err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [3:0]        fifo_addr [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [DEPTH-1:0]  live, live_nxt;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;
  logic [SW-1:0]     starve, starve_nxt;
  logic              alu_acc, ld_acc, fifo_ne, do_pop;

  assign ld_ready = (count != CW'(DEPTH));

  always_comb begin
    alu_acc  = alu_valid & ~alu_stall;
    ld_acc   = ld_valid & ld_ready;
    fifo_ne  = (count != '0);
    // A stalled ALU is never accepted, so the forced pop and the idle pop collapse here.
    do_pop   = fifo_ne & ~alu_acc;
    starve_nxt = '0;
    if (fifo_ne && !do_pop) starve_nxt = starve + SW'(1);
    live_nxt = live;
    for (int i = 0; i < DEPTH; i++) begin
      if (alu_acc && (fifo_addr[i] == alu_addr)) live_nxt[i] = 1'b0;
    end
    if (do_pop) live_nxt[rd_ptr] = 1'b0;
    if (ld_acc) live_nxt[wr_ptr] = 1'b1;
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i]) pend_mask[fifo_addr[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_acc) begin
      fifo_addr[wr_ptr] <= ld_addr;
      fifo_data[wr_ptr] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      live        <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      starve      <= '0;
      alu_stall   <= 1'b0;
      wb_data     <= '0;
      wb_enable   <= '0;
      wb_flags    <= '0;
      wb_flags_en <= 1'b0;
      err         <= 1'b0;
    end else begin
      wb_data   <= '0;
      wb_enable <= '0;
      if (alu_acc) begin
        wb_enable <= 16'h0001 << alu_addr;
        wb_data   <= alu_data;
      end else if (do_pop && live[rd_ptr]) begin
        wb_enable <= 16'h0001 << fifo_addr[rd_ptr];
        wb_data   <= fifo_data[rd_ptr];
      end
      wb_flags_en <= alu_fvalid & ~alu_stall;
      wb_flags    <= (alu_fvalid & ~alu_stall) ? alu_flags : '0;
      live <= live_nxt;
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      if (ld_acc) wr_ptr <= wr_ptr + PW'(1);
      if (ld_acc && !do_pop) count <= count + CW'(1);
      else if (!ld_acc && do_pop) count <= count - CW'(1);
      starve    <= starve_nxt;
      alu_stall <= (starve_nxt == SW'(STARVE_MAX));
      if (alu_valid && alu_stall) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_reg_writeback.sv
// tb/tb_reg_writeback.sv - self-checking bench for reg_writeback against a queue-based reference model
module tb_reg_writeback;
  localparam int DEPTH = 4;
  localparam int STARVE_MAX = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        alu_valid = 1'b0, alu_fvalid = 1'b0, ld_valid = 1'b0;
  logic [3:0]  alu_addr = '0, ld_addr = '0;
  logic [15:0] alu_data = '0, ld_data = '0;
  logic [4:0]  alu_flags = '0;
  logic        alu_stall, ld_ready, wb_flags_en, err;
  logic [15:0] wb_data, wb_enable, pend_mask;
  logic [4:0]  wb_flags;

  reg_writeback #(.DATA_W(16), .FLAG_W(5), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .alu_fvalid(alu_fvalid), .alu_flags(alu_flags), .alu_stall(alu_stall),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .wb_data(wb_data), .wb_enable(wb_enable), .wb_flags(wb_flags),
    .wb_flags_en(wb_flags_en), .pend_mask(pend_mask), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
    bit          live;
  } ent_t;
  ent_t q[$];
  int          m_starve = 0;
  bit          m_stall = 0, m_err = 0;
  logic [15:0] exp_en = '0, exp_data = '0;
  bit          exp_fen = 0;
  logic [4:0]  exp_flags = '0;

  function automatic logic [15:0] m_pend();
    logic [15:0] p = '0;
    foreach (q[i]) if (q[i].live) p[q[i].addr] = 1'b1;
    return p;
  endfunction

  // Drives one cycle of inputs, advances the reference model, and returns #1 after the edge.
  task automatic step(input bit rst, input bit av, input logic [3:0] aa, input logic [15:0] ad,
                      input bit fv, input logic [4:0] fl,
                      input bit lv, input logic [3:0] la, input logic [15:0] ld);
    bit alu_acc, ld_acc, nonempty, popped;
    ent_t e;
    reset = rst; alu_valid = av; alu_addr = aa; alu_data = ad;
    alu_fvalid = fv; alu_flags = fl; ld_valid = lv; ld_addr = la; ld_data = ld;
    if (!rst) begin
      q.delete(); m_starve = 0; m_stall = 0; m_err = 0;
      exp_en = '0; exp_data = '0; exp_fen = 0; exp_flags = '0;
    end else begin
      alu_acc  = av && !m_stall;
      ld_acc   = lv && (q.size() < DEPTH);
      nonempty = q.size() > 0;
      popped   = 0;
      exp_en = '0; exp_data = '0;
      if (alu_acc) begin
        exp_en = 16'h0001 << aa; exp_data = ad;
        foreach (q[i]) if (q[i].addr == aa) q[i].live = 0;
      end else if (nonempty) begin
        e = q.pop_front(); popped = 1;
        if (e.live) begin exp_en = 16'h0001 << e.addr; exp_data = e.data; end
      end
      if (ld_acc) q.push_back('{addr: la, data: ld, live: 1'b1});
      exp_fen = fv && !m_stall;
      exp_flags = exp_fen ? fl : 5'd0;
      if (av && m_stall) m_err = 1;
      if (popped || !nonempty) m_starve = 0; else m_starve++;
      m_stall = (m_starve == STARVE_MAX);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(1, 0, 4'd0, 16'd0, 0, 5'd0, 0, 4'd0, 16'd0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 4'd2, 16'h1234, 1, 5'h1F, 1, 4'd3, 16'h5678);
      checks++;
      if ({wb_enable, wb_data, wb_flags_en, wb_flags, pend_mask, alu_stall, err} !== '0 || ld_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_state: en=%h data=%h fen=%b flags=%h pend=%h stall=%b err=%b ready=%b (want all 0, ready=1)",
                 wb_enable, wb_data, wb_flags_en, wb_flags, pend_mask, alu_stall, err, ld_ready);
      end
    end
    step(1, 1, 4'd7, 16'h0777, 0, 5'd0, 0, 4'd0, 16'd0);
    checks++;
    if (wb_enable !== 16'h0080 || wb_data !== 16'h0777) begin
      errors++; $display("FAIL first_write: en=%h data=%h want 0080 0777", wb_enable, wb_data);
    end
    idle();
  endtask

  task automatic test_alu_write();
    step(1, 1, 4'd3, 16'hBEEF, 1, 5'b10010, 0, 4'd0, 16'd0);
    checks++;
    if (wb_enable !== 16'h0008 || wb_data !== 16'hBEEF || wb_flags_en !== 1'b1 || wb_flags !== 5'b10010) begin
      errors++;
      $display("FAIL alu_write: en=%h data=%h fen=%b flags=%b want 0008 BEEF 1 10010", wb_enable, wb_data, wb_flags_en, wb_flags);
    end
    idle();
    checks++;
    if ({wb_enable, wb_data, wb_flags_en, wb_flags} !== '0) begin
      errors++; $display("FAIL alu_write_clear: en=%h data=%h fen=%b flags=%b want 0", wb_enable, wb_data, wb_flags_en, wb_flags);
    end
  endtask

  task automatic test_fill_fifo();
    int n;
    for (int i = 1; i <= 4; i++) step(1, 1, 4'd10, 16'h0A00 + 16'(i), 0, 5'd0, 1, 4'(i), 16'h0100 * 16'(i));
    checks++;
    if (ld_ready !== 1'b0 || pend_mask !== 16'h001E) begin
      errors++; $display("FAIL fill_full: ready=%b pend=%h want 0 001E", ld_ready, pend_mask);
    end
    n = 4;
    while (alu_stall !== 1'b1 && n < 20) begin
      step(1, 1, 4'd10, 16'h0A55, 0, 5'd0, 0, 4'd0, 16'd0);
      n++;
    end
    checks++;
    if (n != 9) begin
      errors++; $display("FAIL stall_timing: stall after %0d cycles want 9", n);
    end
    idle();
    checks++;
    if (wb_enable !== 16'h0002 || wb_data !== 16'h0100 || alu_stall !== 1'b0) begin
      errors++; $display("FAIL forced_pop: en=%h data=%h stall=%b want 0002 0100 0", wb_enable, wb_data, alu_stall);
    end
    for (int i = 2; i <= 4; i++) begin
      idle();
      checks++;
      if (wb_enable !== (16'h0001 << i) || wb_data !== 16'h0100 * 16'(i)) begin
        errors++; $display("FAIL drain_r%0d: en=%h data=%h", i, wb_enable, wb_data);
      end
    end
    idle();
  endtask

  task automatic test_kill();
    logic [15:0] r5 = 16'h0000;
    step(1, 0, 4'd0, 16'd0, 0, 5'd0, 1, 4'd5, 16'h1111);
    checks++;
    if (pend_mask !== 16'h0020) begin errors++; $display("FAIL kill_pend_set: pend=%h want 0020", pend_mask); end
    step(1, 1, 4'd5, 16'h2222, 0, 5'd0, 0, 4'd0, 16'd0);
    if (wb_enable[5]) r5 = wb_data;
    checks++;
    if (pend_mask !== 16'h0000 || wb_enable !== 16'h0020) begin
      errors++; $display("FAIL kill_alu: pend=%h en=%h want 0000 0020", pend_mask, wb_enable);
    end
    idle();
    if (wb_enable[5]) r5 = wb_data;
    checks++;
    if (wb_enable !== 16'h0000) begin errors++; $display("FAIL kill_pop: en=%h want 0000", wb_enable); end
    checks++;
    if (r5 !== 16'h2222) begin errors++; $display("FAIL kill_final_r5: got %h want 2222", r5); end
  endtask

  task automatic test_same_cycle();
    step(1, 1, 4'd6, 16'hAAAA, 0, 5'd0, 1, 4'd6, 16'hBBBB);
    checks++;
    if (wb_enable !== 16'h0040 || wb_data !== 16'hAAAA || pend_mask !== 16'h0040) begin
      errors++; $display("FAIL same_alu: en=%h data=%h pend=%h want 0040 AAAA 0040", wb_enable, wb_data, pend_mask);
    end
    idle();
    checks++;
    if (wb_enable !== 16'h0040 || wb_data !== 16'hBBBB) begin
      errors++; $display("FAIL same_load: en=%h data=%h want 0040 BBBB", wb_enable, wb_data);
    end
  endtask

  task automatic test_err();
    int n = 0;
    step(1, 1, 4'd11, 16'h0B0B, 0, 5'd0, 1, 4'd9, 16'h9999);
    while (alu_stall !== 1'b1 && n < 20) begin
      step(1, 1, 4'd11, 16'h0B0B, 0, 5'd0, 0, 4'd0, 16'd0);
      n++;
    end
    checks++;
    if (alu_stall !== 1'b1) begin errors++; $display("FAIL err_stall_timeout: stall=%b want 1", alu_stall); end
    step(1, 1, 4'd12, 16'h5555, 0, 5'd0, 0, 4'd0, 16'd0);
    checks++;
    if (err !== 1'b1 || wb_enable !== 16'h0200 || wb_data !== 16'h9999) begin
      errors++; $display("FAIL err_set: err=%b en=%h data=%h want 1 0200 9999", err, wb_enable, wb_data);
    end
    idle(); idle();
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: err=%b want 1", err); end
    step(0, 0, 4'd0, 16'd0, 0, 5'd0, 0, 4'd0, 16'd0);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_clear: err=%b want 0", err); end
  endtask

  task automatic test_random();
    logic [31:0] r, d;
    bit rst;
    for (int c = 0; c < 600; c++) begin
      r = $urandom; d = $urandom;
      rst = (r[5:0] != 6'd0);
      step(rst, r[6] & r[7] & ~alu_stall, 4'(r[10:8]), d[15:0], r[11], r[16:12],
           r[17] | r[18], 4'(r[21:19]), d[31:16]);
      checks++;
      if ({wb_enable, wb_data, wb_flags_en, wb_flags, pend_mask, ld_ready, alu_stall, err} !==
          {exp_en, exp_data, exp_fen, exp_flags, m_pend(), (q.size() < DEPTH), m_stall, m_err}) begin
        errors++;
        $display("FAIL random_c%0d: en=%h data=%h fen=%b fl=%h pend=%h rdy=%b stall=%b err=%b / want %h %h %b %h %h %b %b %b",
                 c, wb_enable, wb_data, wb_flags_en, wb_flags, pend_mask, ld_ready, alu_stall, err,
                 exp_en, exp_data, exp_fen, exp_flags, m_pend(), (q.size() < DEPTH), m_stall, m_err);
      end
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_alu_write();
    test_fill_fifo();
    test_kill();
    test_same_cycle();
    test_err();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Write-side front end of the 16 x 16-bit register file. It merges the ALU result stream and the load-return stream into one write per cycle.
- Drives the register file's data input, its one-hot register enable vector, and its flag write port.
- Buffers load returns in a small FIFO with a ready/valid handshake.
- Publishes a pending-write mask so operand fetch can stall on queued writes.

Parameters:
DATA_W, 16, data width of register writes
FLAG_W, 5, flag vector width
DEPTH, 4, load FIFO entries (power of two, >=2)
STARVE_MAX, 8, consecutive cycles a non-empty FIFO may be blocked by the ALU before alu_stall asserts

Ports:
clk  in  1  clock; all state changes on posedge
reset  in  1  synchronous, active-low reset; sampled on posedge clk, 0 = reset
alu_valid  in  1  ALU write request this cycle (no ready; always accepted unless alu_stall=1)
alu_addr  in  4  ALU destination register
alu_data  in  DATA_W  ALU result
alu_fvalid  in  1  ALU flag write request
alu_flags  in  FLAG_W  ALU flag value
alu_stall  out  1  upstream must hold off ALU writes this cycle
ld_valid  in  1  load return valid
ld_ready  out  1  FIFO can accept (= not full)
ld_addr  in  4  load destination register
ld_data  in  DATA_W  load data
wb_data  out  DATA_W  register file write data
wb_enable  out  16  one-hot register write enable (at most one bit set)
wb_flags  out  FLAG_W  flag register write data
wb_flags_en  out  1  flag register write enable
pend_mask  out  16  bit r set while a live FIFO entry targets register r
err  out  1  sticky protocol error

Behaviour:
- Reset (reset=0 at posedge): all outputs 0, FIFO empty, starvation count 0, err cleared. This also applies mid-operation: queued loads are discarded and no write is issued on the following cycle.
- Acceptance and ordering:
  - Load accepted when ld_valid & ld_ready.
  - ALU accepted when alu_valid & !alu_stall.
  - Same-cycle acceptance: the load is younger than the ALU write.
- Issue arbitration, one write per cycle, priority in this order:
  1. alu_stall=1 and FIFO non-empty: pop the head.
  2. ALU accepted: issue the ALU write.
  3. FIFO non-empty: pop the head.
- Issue output timing: a write issued in cycle N appears on wb_data/wb_enable in cycle N+1, for exactly one cycle. Outputs are registered.
- Latency:
  - ALU write: 1 cycle.
  - Load into an empty FIFO, no ALU traffic: 2 cycles (push N, pop N+1, wb_enable N+2).
- Kill rule: an ALU write accepted in cycle N to address A clears the live bit of every FIFO entry already holding A (entries pushed before N).
  - Killed entries still occupy slots.
  - A killed entry pops normally but produces wb_enable=0.
  - A younger load to A pushed in N is not killed.
- pend_mask: OR of the one-hot decode of live entries. Updated on the same posedge as push/pop/kill.
- Flags: ALU flags are independent of data arbitration. alu_fvalid accepted in N gives wb_flags_en=1 and wb_flags=alu_flags in N+1. Loads never write flags.
- FIFO:
  - Circular, log2(DEPTH)-bit pointers plus a count; pointers wrap from DEPTH-1 to 0.
  - ld_ready = (count != DEPTH), driven from state.
  - Push and pop in the same cycle leaves count unchanged. Push when full is impossible.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and an ALU write is issued instead of a pop.
  - Resets to 0 on any pop or when the FIFO is empty.
  - alu_stall = (counter == STARVE_MAX), registered. It holds for exactly the cycle in which the forced pop occurs, then the counter clears.
- err: sets and stays set until reset if alu_valid=1 while alu_stall=1. That ALU request is dropped.

Test Plan:
- Reset: hold reset=0 for 2 cycles with ALU and load traffic active -> all outputs 0, ld_ready=1; first write appears only after reset=1.
- ALU write: alu_addr=3, alu_data=16'hBEEF, alu_fvalid=1, alu_flags=5'b10010 at cycle N -> in N+1, wb_enable=16'h0008, wb_data=16'hBEEF, wb_flags_en=1, wb_flags=5'b10010; all zero at N+2.
- Fill FIFO: push loads to r1,r2,r3,r4 while alu_valid=1 continuously -> ld_ready=0 after the 4th push; pend_mask=16'h001E; alu_stall=1 after 8 blocked cycles; a forced pop writes r1 (wb_enable=16'h0002).
- Kill: queue a load to r5 (data 16'h1111), then ALU write to r5 with 16'h2222 -> pend_mask bit 5 clears next cycle; the later pop gives wb_enable=0; r5 ends at 16'h2222.
- Same-cycle push and ALU to r6: ALU 16'hAAAA, load 16'hBBBB -> ALU writes r6 first; the load is not killed and later writes 16'hBBBB.
- Protocol error: alu_valid=1 while alu_stall=1 -> err=1 sticky, that ALU write is absent; err cleared only by reset=0.
